// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared state encodings and default widths for the adder datapath
//
// Purpose : types and constants shared by the adder result accumulator and its interface.
// Contents: state_t (IDLE / ACCUM / DONE), ADDER_N (sum bus width), ACC_COUNT (results per batch).
package adder_pkg;

  localparam int ADDER_N   = 8;
  localparam int ACC_COUNT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// rtl/adder_result_accumulator_if.sv - valid/ready result input and batch-total output bundle
//
// Purpose : groups the adder-result input handshake and the batch-total output handshake.
// Signals : in_valid/in_ready/sum_in/carry_in   adder result stream into the accumulator
//           out_valid/out_ready/acc_out/ovf     batch total stream out of the accumulator
// Modports: master - upstream adder plus downstream consumer side
//           slave  - accumulator side
interface adder_result_accumulator_if
  import adder_pkg::*;
#(
  parameter int N     = ADDER_N,
  parameter int ACC_W = ADDER_N + 1 + $clog2(ACC_COUNT)
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     sum_in;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );

endinterface

// File: rtl/adder_result_accumulator.sv
// rtl/adder_result_accumulator.sv - accumulates COUNT adder results into a batch total
//
// Purpose : captures each {carry, sum} adder result over a valid/ready input, sums COUNT of
//           them into an ACC_W-bit total and presents it on a valid/ready output with a
//           sticky overflow flag.
// Ports   : clk       rising-edge clock
//           rst       synchronous active-high reset (overrides everything)
//           clear     synchronous batch abort (below rst)
//           bus       slave side of adder_result_accumulator_if
//           beat_cnt  results accepted in the current batch
module adder_result_accumulator
  import adder_pkg::*;
#(
  parameter int N     = ADDER_N,
  parameter int COUNT = ACC_COUNT,
  parameter int ACC_W = N + 1 + $clog2(COUNT),
  localparam int CW   = $clog2(COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  adder_result_accumulator_if.slave   bus,
  output logic [CW-1:0]               beat_cnt
);

  localparam int          AW1  = ACC_W + 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic             accept;
  logic [ACC_W:0]   sum_ext;

  // Handshake flags decode straight from the registered state.
  assign bus.in_ready  = (state != ST_DONE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_q;

  // A beat presented together with clear is dropped, not counted.
  assign accept = bus.in_valid && bus.in_ready && !clear;

  // One extra bit captures the carry-out of the ACC_W-bit add for the overflow flag.
  assign sum_ext = {1'b0, acc} + AW1'({bus.carry_in, bus.sum_in});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ST_IDLE;
      acc      <= '0;
      ovf_q    <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc   <= sum_ext[ACC_W-1:0];
            ovf_q <= ovf_q | sum_ext[ACC_W];
            if (beat_cnt == LAST) begin
              beat_cnt <= '0;
              state    <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              state    <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          // Total and flag are held until the consumer takes them.
          if (bus.out_ready) begin
            state <= ST_IDLE;
            acc   <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb/tb_adder_result_accumulator.sv - self-checking bench for adder_result_accumulator
module tb_adder_result_accumulator;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, clear_a, rst_b, clear_b;
  logic [1:0] cnt_a, cnt_b;

  adder_result_accumulator_if #(.N(8), .ACC_W(11)) ia();
  adder_result_accumulator_if #(.N(8), .ACC_W(9))  ib();

  adder_result_accumulator #(.N(8), .COUNT(4), .ACC_W(11)) dut_a (
    .clk(clk), .rst(rst_a), .clear(clear_a), .bus(ia.slave), .beat_cnt(cnt_a)
  );

  adder_result_accumulator #(.N(8), .COUNT(4), .ACC_W(9)) dut_b (
    .clk(clk), .rst(rst_b), .clear(clear_b), .bus(ib.slave), .beat_cnt(cnt_b)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       c;
    logic [7:0] s;
    int         e_cnt;
    int         e_acc;
    bit         e_valid;
  } vec_t;
  vec_t vecs[4];

  int m_acc;
  bit m_ovf;
  int m_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Reference accumulator: pushes the expected batch total when the COUNT-th beat is driven.
  task automatic model_beat(input logic c, input logic [7:0] s, input int accw);
    exp_t e;
    m_acc = m_acc + int'({c, s});
    if (m_acc >= (1 << accw)) begin
      m_acc = m_acc - (1 << accw);
      m_ovf = 1'b1;
    end
    m_cnt++;
    if (m_cnt == 4) begin
      e.acc = m_acc;
      e.ovf = m_ovf;
      sb.push_back(e);
      model_reset();
    end
  endtask

  task automatic beat_a(input logic c, input logic [7:0] s);
    ia.in_valid = 1'b1;
    ia.carry_in = c;
    ia.sum_in   = s;
    model_beat(c, s, 11);
    tick();
    ia.in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic c, input logic [7:0] s);
    ib.in_valid = 1'b1;
    ib.carry_in = c;
    ib.sum_in   = s;
    model_beat(c, s, 9);
    tick();
    ib.in_valid = 1'b0;
  endtask

  // Output handshake: compare against the scoreboard, then confirm the drain to IDLE.
  task automatic handshake(input bit use_b);
    exp_t e;
    logic [31:0] acc_v, ovf_v, val_v;
    val_v = use_b ? 32'(ib.out_valid) : 32'(ia.out_valid);
    acc_v = use_b ? 32'(ib.acc_out)   : 32'(ia.acc_out);
    ovf_v = use_b ? 32'(ib.ovf)       : 32'(ia.ovf);
    check("hs_out_valid", val_v, 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_acc", acc_v, 32'(e.acc));
      check("sb_ovf", ovf_v, 32'(e.ovf));
    end
    if (use_b) ib.out_ready = 1'b1; else ia.out_ready = 1'b1;
    tick();
    ib.out_ready = 1'b0;
    ia.out_ready = 1'b0;
    val_v = use_b ? 32'(ib.out_valid) : 32'(ia.out_valid);
    acc_v = use_b ? 32'(ib.acc_out)   : 32'(ia.acc_out);
    ovf_v = use_b ? 32'(ib.ovf)       : 32'(ia.ovf);
    check("post_hs_valid", val_v, 32'd0);
    check("post_hs_acc", acc_v, 32'd0);
    check("post_hs_ovf", ovf_v, 32'd0);
  endtask

  initial begin
    int waited;
    vecs[0] = '{c: 1'b0, s: 8'h10, e_cnt: 1, e_acc: 'h010, e_valid: 1'b0};
    vecs[1] = '{c: 1'b0, s: 8'h20, e_cnt: 2, e_acc: 'h030, e_valid: 1'b0};
    vecs[2] = '{c: 1'b1, s: 8'h00, e_cnt: 3, e_acc: 'h130, e_valid: 1'b0};
    vecs[3] = '{c: 1'b0, s: 8'hFF, e_cnt: 0, e_acc: 'h22F, e_valid: 1'b1};

    ia.in_valid = 1'b0; ia.sum_in = '0; ia.carry_in = 1'b0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.sum_in = '0; ib.carry_in = 1'b0; ib.out_ready = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    model_reset();

    // Reset
    tick();
    tick();
    check("rst_out_valid", 32'(ia.out_valid), 32'd0);
    check("rst_acc", 32'(ia.acc_out), 32'd0);
    check("rst_ovf", 32'(ia.ovf), 32'd0);
    check("rst_beat_cnt", 32'(cnt_a), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("rel_in_ready_a", 32'(ia.in_ready), 32'd1);
    check("rel_in_ready_b", 32'(ib.in_ready), 32'd1);

    // Back-to-back batch from the vector table
    for (int i = 0; i < 4; i++) begin
      ia.in_valid = 1'b1;
      ia.carry_in = vecs[i].c;
      ia.sum_in   = vecs[i].s;
      model_beat(vecs[i].c, vecs[i].s, 11);
      tick();
      check($sformatf("vec%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_acc", i), 32'(ia.acc_out), 32'(vecs[i].e_acc));
      check($sformatf("vec%0d_valid", i), 32'(ia.out_valid), 32'(vecs[i].e_valid));
    end
    check("batch_ovf", 32'(ia.ovf), 32'd0);

    // Backpressure: in_valid keeps toggling data but DONE ignores it
    ia.sum_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_acc", 32'(ia.acc_out), 32'h22F);
      check("bp_in_ready", 32'(ia.in_ready), 32'd0);
      check("bp_beat_cnt", 32'(cnt_a), 32'd0);
    end
    ia.in_valid = 1'b0;
    handshake(1'b0);

    // Overflow on the 9-bit accumulator
    beat_b(1'b1, 8'hFF);
    beat_b(1'b0, 8'h01);
    beat_b(1'b0, 8'h05);
    beat_b(1'b0, 8'h03);
    check("ovf_acc", 32'(ib.acc_out), 32'h008);
    check("ovf_flag", 32'(ib.ovf), 32'd1);
    handshake(1'b1);

    // Clear mid-batch with a colliding beat
    beat_a(1'b0, 8'h01);
    beat_a(1'b0, 8'h01);
    check("pre_clear_cnt", 32'(cnt_a), 32'd2);
    clear_a = 1'b1;
    ia.in_valid = 1'b1;
    ia.sum_in = 8'h40;
    tick();
    model_reset();
    clear_a = 1'b0;
    ia.in_valid = 1'b0;
    check("clear_cnt", 32'(cnt_a), 32'd0);
    check("clear_acc", 32'(ia.acc_out), 32'd0);
    check("clear_valid", 32'(ia.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) beat_a(1'b0, 8'h01);
    check("post_clear_acc", 32'(ia.acc_out), 32'h004);
    handshake(1'b0);

    // Reset while a completed batch waits
    for (int i = 0; i < 4; i++) beat_a(1'b0, 8'h03);
    check("rd_valid_before", 32'(ia.out_valid), 32'd1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    sb.delete();
    model_reset();
    check("rd_valid_after", 32'(ia.out_valid), 32'd0);
    check("rd_acc_after", 32'(ia.acc_out), 32'd0);
    beat_a(1'b0, 8'h02);
    beat_a(1'b0, 8'h04);
    beat_a(1'b0, 8'h08);
    beat_a(1'b1, 8'h00);
    waited = 0;
    while (!ia.out_valid && waited < 10) begin
      tick();
      waited++;
    end
    check("rd_fresh_timeout", 32'(ia.out_valid), 32'd1);
    check("rd_fresh_acc", 32'(ia.acc_out), 32'h10E);
    handshake(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
